// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default oversampling ratio and
// the parity helper used by the transmitter and receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_START  = 3'd1;
  localparam logic [2:0] STATE_DATA   = 3'd2;
  localparam logic [2:0] STATE_PARITY = 3'd3;
  localparam logic [2:0] STATE_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = STATE_IDLE,
    ST_START  = STATE_START,
    ST_DATA   = STATE_DATA,
    ST_PARITY = STATE_PARITY,
    ST_STOP   = STATE_STOP
  } uart_state_e;

  // Callers zero-extend narrower words; the extra zeros do not change the result.
  function automatic logic parity_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits,
// timed by a shared 16x baud tick, with a one-word holding register for back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick_16x,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output uart_state_e          dbg_state
);

  // Handshake: a word is taken on a rising clk edge where tx_valid && tx_ready;
  // tx_ready depends only on the holding-register flag, never on tx_valid.

  localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 bit_end;
  logic                 load_hold;
  logic                 load_direct;
  logic [DATA_BITS-1:0] load_data;
  logic [7:0]           par_in;

  assign accept  = tx_valid && !hold_full_q;
  assign bit_end = baud_tick_16x && (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    load_hold   = 1'b0;
    load_direct = 1'b0;
    load_data   = hold_q;
    par_in      = '0;
    tx_d        = 1'b1;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (state_q != ST_IDLE && baud_tick_16x) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) load_hold = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            // A word arriving on the very last tick bypasses the hold register.
            if (hold_full_q)  load_hold   = 1'b1;
            else if (accept)  load_direct = 1'b1;
            else              state_d     = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_hold || load_direct) begin
      load_data                 = load_hold ? hold_q : tx_data;
      par_in[DATA_BITS-1:0]     = load_data;
      shift_d                   = load_data;
      par_d                     = parity_calc(par_in, PARITY_ODD != 0);
      hold_full_d               = 1'b0;
      state_d                   = ST_START;
      tick_cnt_d                = '0;
      bit_cnt_d                 = '0;
    end

    // Line level is derived from the next state so tx itself is a plain register.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign tx_ready  = !hold_full_q;
  assign tx        = tx_q;
  assign tx_busy   = (state_q != ST_IDLE);
  assign tx_done   = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 7O1) driven with random and
// directed words; a line decoder compares every tick of every frame against a frame model.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int OS = 16;
  localparam int NDUT = 3;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [7:0]  data_w  [NDUT];
  logic        valid_w [NDUT];
  logic        ready_w [NDUT];
  logic        tx_w    [NDUT];
  logic        busy_w  [NDUT];
  logic        done_w  [NDUT];
  uart_state_e dbg_w   [NDUT];

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .baud_tick_16x(tick), .tx_data(data_w[0]), .tx_valid(valid_w[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .dbg_state(dbg_w[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .baud_tick_16x(tick), .tx_data(data_w[1]), .tx_valid(valid_w[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .dbg_state(dbg_w[1]));
  uart_tx #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .baud_tick_16x(tick), .tx_data(data_w[2][6:0]), .tx_valid(valid_w[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .dbg_state(dbg_w[2]));

  // Per-instance frame format.
  function automatic int cfg_db(input int k);  return (k == 2) ? 7 : 8; endfunction
  function automatic int cfg_pe(input int k);  return (k == 0) ? 0 : 1; endfunction
  function automatic int cfg_odd(input int k); return (k == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(input int k);  return (k == 1) ? 2 : 1; endfunction
  function automatic int frame_bits(input int k);
    return 1 + cfg_db(k) + cfg_pe(k) + cfg_sb(k);
  endfunction

  // ---------------- clock / reset / baud tick ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // baud divider of 5: tick high for one clk out of every five
  initial begin
    tick = 1'b0;
    forever begin
      repeat (4) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic push_exp(input int k, input logic [7:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic pop_exp(input int k, output logic [7:0] v);
    case (k)
      0: v = exp_q0.pop_front();
      1: v = exp_q1.pop_front();
      default: v = exp_q2.pop_front();
    endcase
  endtask

  task automatic clear_exp();
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
  endtask

  // ---------------- line monitor ----------------
  bit         mon_active [NDUT];
  bit         done_due   [NDUT];
  int         mon_t      [NDUT];
  int         mon_err    [NDUT];
  int         mon_first  [NDUT];
  logic [7:0] mon_byte   [NDUT];
  logic       mon_lv     [NDUT][16];
  int         frames     [NDUT];
  int         done_cnt   [NDUT];

  // Frame model: list of line levels, one per bit period.
  task automatic build_frame(input int k, input logic [7:0] b);
    int n;
    int ones;
    n = 0;
    ones = 0;
    mon_lv[k][n] = 1'b0; n++;
    for (int i = 0; i < cfg_db(k); i++) begin
      mon_lv[k][n] = ((b >> i) % 2) == 1; n++;
      ones += ((b >> i) % 2);
    end
    if (cfg_pe(k) != 0) begin
      mon_lv[k][n] = ((ones % 2) == 1) ^ (cfg_odd(k) != 0); n++;
    end
    for (int i = 0; i < cfg_sb(k); i++) begin
      mon_lv[k][n] = 1'b1; n++;
    end
  endtask

  task automatic mon_step(input int k);
    logic [7:0] b;
    int bitn;
    if (rst) begin
      mon_active[k] = 0;
      done_due[k]   = 0;
      return;
    end
    if (done_due[k]) begin
      chk(done_w[k] == 1'b1, $sformatf("dut%0d tx_done after frame 0x%02h", k, mon_byte[k]), done_w[k], 1);
      frames[k]++;
      done_due[k] = 0;
    end
    if (!mon_active[k] && tx_w[k] == 1'b0) begin
      b = 8'h00;
      if (qsize(k) == 0) chk(0, $sformatf("dut%0d start bit with no word queued", k), qsize(k), 1);
      else pop_exp(k, b);
      build_frame(k, b);
      mon_byte[k]   = b;
      mon_t[k]      = 0;
      mon_err[k]    = 0;
      mon_first[k]  = -1;
      mon_active[k] = 1;
    end
    if (mon_active[k] && tick) begin
      bitn = mon_t[k] / OS;
      if (tx_w[k] !== mon_lv[k][bitn]) begin
        mon_err[k]++;
        if (mon_first[k] < 0) mon_first[k] = bitn;
      end
      mon_t[k]++;
      if (mon_t[k] == frame_bits(k) * OS) begin
        chk(mon_err[k] == 0,
            $sformatf("dut%0d frame 0x%02h wrong-level ticks (first bad bit %0d)", k, mon_byte[k], mon_first[k]),
            mon_err[k], 0);
        mon_active[k] = 0;
        done_due[k]   = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (!rst && done_w[k]) done_cnt[k]++;
      mon_step(k);
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic drive_word(input int k, input logic [7:0] v, input bit keep);
    logic [7:0] mask;
    mask = (cfg_db(k) == 7) ? 8'h7F : 8'hFF;
    valid_w[k] = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      if (ready_w[k]) begin
        data_w[k] = v;
        push_exp(k, v & mask);
        @(posedge clk);
        #1;
        if (!keep) valid_w[k] = 1'b0;
        return;
      end
      data_w[k] = 8'($urandom);
      @(posedge clk);
      #1;
    end
    chk(0, $sformatf("dut%0d tx_ready wait timeout", k), 0, 1);
    valid_w[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (qsize(k) == 0 && !mon_active[k] && !done_due[k] && !busy_w[k]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(0, $sformatf("dut%0d drain timeout", k), qsize(k), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_low(input int k);
    bit ok;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_w[k] == 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(0, $sformatf("dut%0d start bit timeout", k), tx_w[k], 0);
  endtask

  // counts tick cycles starting with the current negedge; returns at a negedge
  task automatic count_ticks(input int n);
    int c;
    c = 0;
    for (int i = 0; i < 100 * n; i++) begin
      if (tick) c++;
      if (c == n) break;
      @(negedge clk);
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [7:0] v;
    bit seen;
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      valid_w[k] = 1'b0; data_w[k] = 8'h00; frames[k] = 0; done_cnt[k] = 0;
      mon_active[k] = 0; done_due[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk(tx_w[k] == 1'b1,    $sformatf("dut%0d reset tx", k),       tx_w[k], 1);
      chk(ready_w[k] == 1'b1, $sformatf("dut%0d reset tx_ready", k), ready_w[k], 1);
      chk(busy_w[k] == 1'b0,  $sformatf("dut%0d reset tx_busy", k),  busy_w[k], 0);
      chk(done_w[k] == 1'b0,  $sformatf("dut%0d reset tx_done", k),  done_w[k], 0);
    end
    @(posedge clk); #1;

    // single 8N1 frame
    drive_word(0, 8'hAB, 0);
    wait_idle(0);

    // second write while busy: backlog of one, then chained frames
    drive_word(0, 8'h55, 1);
    drive_word(0, 8'hA3, 0);
    chk(ready_w[0] == 1'b0, "dut0 tx_ready low with word held", ready_w[0], 0);
    seen = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done_w[0]) begin seen = 1; break; end
    end
    chk(seen, "dut0 first tx_done seen", seen, 1);
    chk(tx_w[0] == 1'b0, "dut0 start bit directly after stop bit", tx_w[0], 0);
    wait_idle(0);

    // parity frames: even (8E2) and odd (7O1)
    drive_word(1, 8'h07, 0);
    wait_idle(1);
    drive_word(2, 8'h07, 0);
    wait_idle(2);

    // random bursts, valid held with garbage data while not ready
    fork
      begin
        for (int i = 0; i < 5; i++) drive_word(0, 8'($urandom), i < 4);
        wait_idle(0);
      end
      begin
        for (int i = 0; i < 4; i++) drive_word(1, 8'($urandom), i < 3);
        wait_idle(1);
      end
      begin
        for (int i = 0; i < 5; i++) drive_word(2, 8'($urandom), i < 4);
        wait_idle(2);
      end
    join

    // word offered on the final stop tick is chained without a gap
    drive_word(0, 8'($urandom), 0);
    wait_tx_low(0);
    count_ticks(frame_bits(0) * OS);
    v = 8'($urandom_range(0, 255));
    chk(ready_w[0] == 1'b1, "dut0 tx_ready on last stop tick", ready_w[0], 1);
    valid_w[0] = 1'b1;
    data_w[0]  = v;
    push_exp(0, v);
    @(posedge clk);
    #1 valid_w[0] = 1'b0;
    @(negedge clk);
    chk(done_w[0] == 1'b1, "dut0 tx_done at stop end with accept", done_w[0], 1);
    chk(tx_w[0] == 1'b0,   "dut0 bypassed word starts at once", tx_w[0], 0);
    wait_idle(0);

    // reset in the middle of the data bits
    drive_word(0, 8'($urandom), 0);
    wait_tx_low(0);
    count_ticks(40);
    chk(dbg_w[0] == ST_DATA, "dut0 in DATA before reset", int'(dbg_w[0]), int'(ST_DATA));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_exp();
    @(negedge clk);
    chk(tx_w[0] == 1'b1,    "dut0 tx after mid-frame reset",       tx_w[0], 1);
    chk(busy_w[0] == 1'b0,  "dut0 tx_busy after mid-frame reset",  busy_w[0], 0);
    chk(ready_w[0] == 1'b1, "dut0 tx_ready after mid-frame reset", ready_w[0], 1);
    chk(done_w[0] == 1'b0,  "dut0 tx_done after mid-frame reset",  done_w[0], 0);
    @(posedge clk); #1;
    repeat (100) @(posedge clk);
    #1;
    drive_word(0, 8'h3C, 0);
    wait_idle(0);

    for (int k = 0; k < NDUT; k++) begin
      chk(done_cnt[k] == frames[k], $sformatf("dut%0d tx_done pulse count", k), done_cnt[k], frames[k]);
      chk(qsize(k) == 0, $sformatf("dut%0d words never transmitted", k), qsize(k), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
